// File: rtl/kalman_seq_pkg.sv
// Shared types and sizing helpers for the Kalman filter sample sequencer.
// State encoding is fixed so it can be probed directly in waveforms.
package kalman_seq_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } seq_state_e;

    // The counter must be able to hold TIMEOUT-1.
    function automatic int to_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int TO_CNT_W_DEF = to_cnt_w(TIMEOUT_DEF);

endpackage

// File: rtl/sync_fifo_bypassless.sv
// Single-clock FIFO with registered pointers and count and no write-to-read bypass.
// The head entry is visible on o_rdata whenever o_empty is low.
module sync_fifo_bypassless #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [PTR_W:0]    o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: storage is deliberately not reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/kalman_sample_sequencer.sv
// Buffers raw samples and issues them one at a time to the Kalman filter,
// returning each filtered estimate as a one-cycle result beat.
module kalman_sample_sequencer
    import kalman_seq_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_in_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              sample_in_ready,
    output logic              kf_valid,
    output logic [DATA_W-1:0] kf_measurement,
    input  logic              kf_ready,
    input  logic [DATA_W-1:0] kf_filtered_out,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              busy,
    output logic              overflow_err,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = to_cnt_w(TIMEOUT);

    seq_state_e        r_state;
    logic              r_kf_valid;
    logic [DATA_W-1:0] r_kf_meas;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_kf_ready_q;
    logic              r_busy;
    logic              r_ovf_err;
    logic              r_to_err;

    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_push;
    logic              w_pop;
    logic              w_rdy_edge;
    logic              w_to_hit;
    logic              w_to_evt;
    logic              w_ovf_evt;
    logic              w_busy_next;

    sync_fifo_bypassless #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (sample_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Only a fresh rising ready counts, so a level left high from the last sample is ignored.
    assign w_rdy_edge = kf_ready && !r_kf_ready_q;
    assign w_push     = sample_in_valid && !w_full;
    assign w_ovf_evt  = sample_in_valid && w_full;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_to_evt   = (r_state == WAIT) && !w_rdy_edge && w_to_hit;

    always_comb begin
        w_count_next = w_count;
        if (w_push && !w_pop)      w_count_next = w_count + CNT_W'(1);
        else if (!w_push && w_pop) w_count_next = w_count - CNT_W'(1);
    end

    // busy is registered, so it is derived from where the FSM and FIFO land next cycle.
    assign w_busy_next = !((r_state == GAP) || ((r_state == IDLE) && w_empty))
                         || (w_count_next != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_kf_valid   <= 1'b0;
            r_kf_meas    <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_to_cnt     <= '0;
            r_kf_ready_q <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_kf_ready_q <= kf_ready;
            r_busy       <= w_busy_next;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_kf_meas  <= w_head;
                        r_kf_valid <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_kf_valid <= 1'b0;
                    r_to_cnt   <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (w_rdy_edge) begin
                        r_res_data  <= kf_filtered_out;
                        r_res_valid <= 1'b1;
                        r_state     <= GAP;
                    end else if (w_to_hit) begin
                        r_state <= GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    r_res_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_to_err  <= 1'b0;
        end else begin
            r_ovf_err <= w_ovf_evt || (r_ovf_err && !err_clr);
            r_to_err  <= w_to_evt  || (r_to_err  && !err_clr);
        end
    end

    assign sample_in_ready = !w_full;
    assign kf_valid        = r_kf_valid;
    assign kf_measurement  = r_kf_meas;
    assign result_valid    = r_res_valid;
    assign result_data     = r_res_data;
    assign busy            = r_busy;
    assign overflow_err    = r_ovf_err;
    assign timeout_err     = r_to_err;

endmodule

// File: tb/tb_kalman_sample_sequencer.sv
// Directed bench for kalman_sample_sequencer with a small filter model (pulse or level ready).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_kalman_sample_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_in_valid;
    logic [7:0] sample_in;
    logic       sample_in_ready;
    logic       kf_valid;
    logic [7:0] kf_measurement;
    logic       kf_ready = 1'b0;
    logic [7:0] f_out = 8'd0;
    logic       result_valid;
    logic [7:0] result_data;
    logic       busy;
    logic       overflow_err;
    logic       timeout_err;
    logic       err_clr;

    int total = 0;
    int bad   = 0;

    kalman_sample_sequencer #(
        .DATA_W     (8),
        .FIFO_DEPTH (16),
        .TIMEOUT    (255)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in_valid (sample_in_valid),
        .sample_in       (sample_in),
        .sample_in_ready (sample_in_ready),
        .kf_valid        (kf_valid),
        .kf_measurement  (kf_measurement),
        .kf_ready        (kf_ready),
        .kf_filtered_out (f_out),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .busy            (busy),
        .overflow_err    (overflow_err),
        .timeout_err     (timeout_err),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Filter model: mode 0 never ready, mode 1 one-cycle ready 3 cycles after valid,
    // mode 2 ready held high until the next valid. Estimate is measurement - 2.
    int mode = 0;
    int dly  = 0;
    always @(negedge clk) begin
        if (mode == 1) begin
            kf_ready = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0) kf_ready = 1'b1;
            end
            if (kf_valid) begin
                dly   = 3;
                f_out = kf_measurement - 8'd2;
            end
        end else if (mode == 2) begin
            if (kf_valid) begin
                kf_ready = 1'b0;
                f_out    = kf_measurement - 8'd2;
            end else begin
                kf_ready = 1'b1;
            end
        end else begin
            kf_ready = 1'b0;
            dly      = 0;
        end
    end

    logic [7:0] iss_q[$];
    logic [7:0] res_q[$];
    int         iss_cyc[$];
    always @(negedge clk) begin
        if (kf_valid) begin
            iss_q.push_back(kf_measurement);
            iss_cyc.push_back(cyc);
        end
        if (result_valid) res_q.push_back(result_data);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        iss_q.delete();
        res_q.delete();
        iss_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        sample_in_valid = 1'b0;
        sample_in = 8'd0;
        err_clr = 1'b0;
        repeat (3) tick();

        chk("rst_kf_valid", kf_valid, 0);
        chk("rst_kf_meas", kf_measurement, 0);
        chk("rst_res_valid", result_valid, 0);
        chk("rst_res_data", result_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_to", timeout_err, 0);
        chk("rst_ready", sample_in_ready, 1);
        rst = 1'b0;
        repeat (2) tick();

        // Single sample, pulse-style ready.
        mode = 1;
        clear_logs();
        sample_in_valid = 1'b1;
        sample_in = 8'd57;
        tick();
        sample_in_valid = 1'b0;
        chk("s1_busy_up", busy, 1);
        chk("s1_valid_early", kf_valid, 0);
        tick();
        chk("s1_kf_valid", kf_valid, 1);
        chk("s1_kf_meas", kf_measurement, 57);
        repeat (3) tick();
        chk("s1_res_early", result_valid, 0);
        tick();
        chk("s1_res_valid", result_valid, 1);
        chk("s1_res_data", result_data, 55);
        tick();
        chk("s1_res_pulse", result_valid, 0);
        chk("s1_busy_down", busy, 0);
        repeat (5) tick();
        chk("s1_issue_cnt", iss_q.size(), 1);
        chk("s1_res_cnt", res_q.size(), 1);
        chk("s1_meas_held", kf_measurement, 57);
        chk("s1_data_held", result_data, 55);

        // Back-to-back burst, level-style ready.
        mode = 2;
        tick();
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            sample_in_valid = 1'b1;
            sample_in = 8'(50 + i);
            chk("burst_ready", sample_in_ready, 1);
            tick();
        end
        sample_in_valid = 1'b0;
        for (int k = 0; k < 400 && res_q.size() < 16; k++) tick();
        repeat (10) tick();
        chk("burst_issue_cnt", iss_q.size(), 16);
        chk("burst_res_cnt", res_q.size(), 16);
        if (iss_q.size() == 16 && res_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("burst_meas_%0d", i), iss_q[i], 50 + i);
                chk($sformatf("burst_res_%0d", i), res_q[i], 48 + i);
            end
            for (int i = 1; i < 16; i++)
                chk($sformatf("burst_gap_%0d", i), iss_cyc[i] - iss_cyc[i-1], 4);
        end
        chk("burst_busy_end", busy, 0);

        // Fill FIFO while stuck in WAIT, then time out.
        mode = 0;
        repeat (2) tick();
        clear_logs();
        sample_in_valid = 1'b1;
        sample_in = 8'd100;
        tick();
        sample_in_valid = 1'b0;
        for (int k = 0; k < 10 && !kf_valid; k++) tick();
        chk("ovf_first_issue", kf_valid, 1);
        t = 0;
        tick();
        t++;
        for (int i = 1; i <= 17; i++) begin
            sample_in_valid = 1'b1;
            sample_in = 8'(i);
            if (i <= 16) begin
                chk($sformatf("ovf_ready_%0d", i), sample_in_ready, 1);
            end else begin
                chk("ovf_ready_full", sample_in_ready, 0);
                chk("ovf_not_yet", overflow_err, 0);
            end
            tick();
            t++;
        end
        sample_in_valid = 1'b0;
        chk("ovf_set", overflow_err, 1);
        err_clr = 1'b1;
        sample_in_valid = 1'b1;
        sample_in = 8'd77;
        tick();
        t++;
        err_clr = 1'b0;
        sample_in_valid = 1'b0;
        chk("ovf_clr_vs_evt", overflow_err, 1);
        err_clr = 1'b1;
        tick();
        t++;
        err_clr = 1'b0;
        chk("ovf_cleared", overflow_err, 0);

        repeat (255 - t) tick();
        chk("to_not_yet", timeout_err, 0);
        tick();
        chk("to_set", timeout_err, 1);
        chk("to_no_result", result_valid, 0);
        tick();
        chk("to_idle_no_valid", kf_valid, 0);
        chk("to_full_ready", sample_in_ready, 0);
        chk("to_ovf_pre", overflow_err, 0);
        chk("to_no_result_log", res_q.size(), 0);
        clear_logs();
        mode = 2;
        sample_in_valid = 1'b1;
        sample_in = 8'd99;
        tick();
        sample_in_valid = 1'b0;
        chk("to_next_issue", kf_valid, 1);
        chk("to_next_meas", kf_measurement, 1);
        chk("pp_full_ovf", overflow_err, 1);
        for (int k = 0; k < 300 && res_q.size() < 16; k++) tick();
        repeat (10) tick();
        chk("drain_issue_cnt", iss_q.size(), 16);
        chk("drain_res_cnt", res_q.size(), 16);
        if (iss_q.size() == 16)
            for (int i = 0; i < 16; i++)
                chk($sformatf("drain_meas_%0d", i), iss_q[i], i + 1);
        chk("to_sticky", timeout_err, 1);
        chk("drain_busy", busy, 0);

        // Reset in WAIT with samples queued.
        mode = 0;
        repeat (2) tick();
        clear_logs();
        sample_in_valid = 1'b1;
        sample_in = 8'd200;
        tick();
        sample_in_valid = 1'b0;
        for (int k = 0; k < 10 && !kf_valid; k++) tick();
        chk("rw_issue", kf_valid, 1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            sample_in_valid = 1'b1;
            sample_in = 8'(200 + i);
            tick();
        end
        sample_in_valid = 1'b0;
        repeat (3) tick();
        chk("rw_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_kf_valid", kf_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_ready", sample_in_ready, 1);
        chk("rw_res_valid", result_valid, 0);
        chk("rw_to_clr", timeout_err, 0);
        mode = 2;
        repeat (20) tick();
        chk("rw_no_result", res_q.size(), 0);
        chk("rw_no_reissue", iss_q.size(), 1);
        chk("rw_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
